// File: rtl/pill_log_pkg.sv
// Shared field widths and the record layout of one missed-dose log entry.
// Record order matches the LCD word: {seq, day, hour, minute, pillId}.
package pill_log_pkg;

    localparam int SEQ_W  = 8;
    localparam int DAY_W  = 5;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int PILL_W = 4;
    localparam int REC_W  = SEQ_W + DAY_W + HOUR_W + MIN_W + PILL_W;

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [PILL_W-1:0] pill_id;
    } log_rec_t;

    function automatic log_rec_t pack_rec(
        input logic [SEQ_W-1:0]  seq,
        input logic [DAY_W-1:0]  day,
        input logic [HOUR_W-1:0] hour,
        input logic [MIN_W-1:0]  minute,
        input logic [PILL_W-1:0] pill_id
    );
        log_rec_t r;
        r.seq     = seq;
        r.day     = day;
        r.hour    = hour;
        r.minute  = minute;
        r.pill_id = pill_id;
        return r;
    endfunction

endpackage

// File: rtl/missed_dose_log_ram.sv
// Simple dual-port log storage: one write port, one synchronous read port.
// Read-first on a same-address collision; no reset so it maps to block RAM.
module log_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 28
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_data_q <= mem[raddr];
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/missed_dose_log.sv
// Circular log of missed-dose events feeding the LCD record word, with scroll and clear.
// Optional MISSED_LOG_DUP_FILTER_EN drops a miss that repeats the newest stored record.
module missed_dose_log
    import pill_log_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              missEvent,
    input  logic [3:0]        missPillId,
    input  logic [4:0]        timeDay,
    input  logic [4:0]        timeHour,
    input  logic [5:0]        timeMinute,
    input  logic              scrollOlder,
    input  logic              scrollNewer,
    input  logic              clearLog,
    output logic [27:0]       dataFromRAM,
    output logic [ADDR_W:0]   entryCount,
    output logic [ADDR_W-1:0] viewIdx,
    output logic              logEmpty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic              miss_prev_q, older_prev_q, newer_prev_q, clear_prev_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] view_q, view_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [REC_W-1:0]  data_q, data_d;
    logic [REC_W-1:0]  ram_rdata;
    log_rec_t          wr_rec;
    logic              miss_edge, older_edge, newer_edge, clear_edge;
    logic              is_dup, do_write;

`ifdef MISSED_LOG_DUP_FILTER_EN
    // Fields of the last logged record (everything except seq).
    logic [REC_W-SEQ_W-1:0] shadow_q, shadow_d;

    always_comb begin
        is_dup   = (count_q != '0) && (shadow_q == wr_rec[REC_W-SEQ_W-1:0]);
        shadow_d = do_write ? wr_rec[REC_W-SEQ_W-1:0] : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        miss_edge  = missEvent   & ~miss_prev_q;
        older_edge = scrollOlder & ~older_prev_q;
        newer_edge = scrollNewer & ~newer_prev_q;
        clear_edge = clearLog    & ~clear_prev_q;
        wr_rec     = pack_rec(seq_q, timeDay, timeHour, timeMinute, missPillId);
        do_write   = miss_edge & ~clear_edge & ~is_dup;

        wr_ptr_d   = wr_ptr_q;
        seq_d      = seq_q;
        count_d    = count_q;
        view_d     = view_q;
        overflow_d = overflow_q;

        if (clear_edge) begin
            wr_ptr_d   = '0;
            seq_d      = '0;
            count_d    = '0;
            view_d     = '0;
            overflow_d = 1'b0;
        end else if (do_write) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            seq_d    = seq_q + SEQ_W'(1);
            view_d   = '0;
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end else if ((count_q != '0) && (older_edge ^ newer_edge)) begin
            // Simultaneous older+newer edges cancel out via the XOR above.
            if (older_edge && (({1'b0, view_q} + (ADDR_W+1)'(1)) < count_q)) begin
                view_d = view_q + ADDR_W'(1);
            end else if (newer_edge && (view_q != '0)) begin
                view_d = view_q - ADDR_W'(1);
            end
        end

        rd_addr = wr_ptr_q - ADDR_W'(1) - view_q;
        data_d  = (count_q == '0) ? '0 : ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_prev_q  <= 1'b0;
            older_prev_q <= 1'b0;
            newer_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
            wr_ptr_q     <= '0;
            seq_q        <= '0;
            count_q      <= '0;
            view_q       <= '0;
            overflow_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            miss_prev_q  <= missEvent;
            older_prev_q <= scrollOlder;
            newer_prev_q <= scrollNewer;
            clear_prev_q <= clearLog;
            wr_ptr_q     <= wr_ptr_d;
            seq_q        <= seq_d;
            count_q      <= count_d;
            view_q       <= view_d;
            overflow_q   <= overflow_d;
            data_q       <= data_d;
        end
    end

    log_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (REC_W)
    ) u_log_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr_q),
        .wdata (wr_rec),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign dataFromRAM = data_q;
    assign entryCount  = count_q;
    assign viewIdx     = view_q;
    assign logEmpty    = (count_q == '0);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_missed_dose_log.sv
// Directed bench for missed_dose_log: write, scroll, overflow, clear, level-hold and dup handling.
// Build with MISSED_LOG_DUP_FILTER_EN defined to exercise the duplicate filter.
module tb_missed_dose_log;

    logic        clk = 1'b0;
    logic        reset;
    logic        missEvent;
    logic [3:0]  missPillId;
    logic [4:0]  timeDay;
    logic [4:0]  timeHour;
    logic [5:0]  timeMinute;
    logic        scrollOlder;
    logic        scrollNewer;
    logic        clearLog;
    logic [27:0] dataFromRAM;
    logic [4:0]  entryCount;
    logic [3:0]  viewIdx;
    logic        logEmpty;
    logic        overflow;

    int check_cnt = 0;
    int pass_cnt  = 0;

    missed_dose_log #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .missEvent   (missEvent),
        .missPillId  (missPillId),
        .timeDay     (timeDay),
        .timeHour    (timeHour),
        .timeMinute  (timeMinute),
        .scrollOlder (scrollOlder),
        .scrollNewer (scrollNewer),
        .clearLog    (clearLog),
        .dataFromRAM (dataFromRAM),
        .entryCount  (entryCount),
        .viewIdx     (viewIdx),
        .logEmpty    (logEmpty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Expected LCD word built from its fields.
    function automatic logic [27:0] rec(input logic [7:0] s, input logic [4:0] d,
                                        input logic [4:0] h, input logic [5:0] m,
                                        input logic [3:0] p);
        return {s, d, h, m, p};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle high pulse on the chosen inputs, then one cycle low.
    task automatic pulse(input logic m, input logic o, input logic n, input logic c);
        missEvent = m; scrollOlder = o; scrollNewer = n; clearLog = c;
        tick(1);
        missEvent = 1'b0; scrollOlder = 1'b0; scrollNewer = 1'b0; clearLog = 1'b0;
        tick(1);
    endtask

    task automatic write_rec(input logic [3:0] p, input logic [4:0] d,
                             input logic [4:0] h, input logic [5:0] m);
        missPillId = p; timeDay = d; timeHour = h; timeMinute = m;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        missEvent = 1'b0; scrollOlder = 1'b0; scrollNewer = 1'b0; clearLog = 1'b0;
        missPillId = '0; timeDay = '0; timeHour = '0; timeMinute = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_cnt++; if (dataFromRAM !== 28'h0) $display("FAIL reset_data: got %h exp %h", dataFromRAM, 28'h0); else pass_cnt++;
        check_cnt++; if (entryCount !== 5'd0) $display("FAIL reset_count: got %0d exp 0", entryCount); else pass_cnt++;
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL reset_view: got %0d exp 0", viewIdx); else pass_cnt++;
        check_cnt++; if (logEmpty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", logEmpty); else pass_cnt++;
        check_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", overflow); else pass_cnt++;
    endtask

    task automatic test_three_writes();
        write_rec(4'd1, 5'd4, 5'd8, 6'd0);
        write_rec(4'd2, 5'd4, 5'd8, 6'd1);
        write_rec(4'd3, 5'd4, 5'd8, 6'd2);
        tick(2);
        check_cnt++; if (entryCount !== 5'd3) $display("FAIL three_count: got %0d exp 3", entryCount); else pass_cnt++;
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL three_view: got %0d exp 0", viewIdx); else pass_cnt++;
        check_cnt++; if (logEmpty !== 1'b0) $display("FAIL three_empty: got %b exp 0", logEmpty); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd2, 5'd4, 5'd8, 6'd2, 4'd3))
            $display("FAIL three_data: got %h exp %h", dataFromRAM, rec(8'd2, 5'd4, 5'd8, 6'd2, 4'd3)); else pass_cnt++;
    endtask

    task automatic test_scroll();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        check_cnt++; if (dataFromRAM !== rec(8'd1, 5'd4, 5'd8, 6'd1, 4'd2))
            $display("FAIL scroll_one_data: got %h exp %h", dataFromRAM, rec(8'd1, 5'd4, 5'd8, 6'd1, 4'd2)); else pass_cnt++;
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        check_cnt++; if (viewIdx !== 4'd2) $display("FAIL scroll_clamp_view: got %0d exp 2", viewIdx); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd0, 5'd4, 5'd8, 6'd0, 4'd1))
            $display("FAIL scroll_oldest_data: got %h exp %h", dataFromRAM, rec(8'd0, 5'd4, 5'd8, 6'd0, 4'd1)); else pass_cnt++;
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL scroll_newer_view: got %0d exp 0", viewIdx); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd2, 5'd4, 5'd8, 6'd2, 4'd3))
            $display("FAIL scroll_newest_data: got %h exp %h", dataFromRAM, rec(8'd2, 5'd4, 5'd8, 6'd2, 4'd3)); else pass_cnt++;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check_cnt++; if (viewIdx !== 4'd1) $display("FAIL scroll_both_view: got %0d exp 1", viewIdx); else pass_cnt++;
    endtask

    task automatic test_overflow();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            write_rec(4'(i), 5'd10, 5'd20, 6'(i));
            if (i == 15) begin
                check_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_not_yet: got %b exp 0", overflow); else pass_cnt++;
                check_cnt++; if (entryCount !== 5'd16) $display("FAIL ovf_full_count: got %0d exp 16", entryCount); else pass_cnt++;
            end
        end
        tick(2);
        check_cnt++; if (entryCount !== 5'd16) $display("FAIL ovf_count: got %0d exp 16", entryCount); else pass_cnt++;
        check_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", overflow); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd17, 5'd10, 5'd20, 6'd17, 4'd1))
            $display("FAIL ovf_newest_data: got %h exp %h", dataFromRAM, rec(8'd17, 5'd10, 5'd20, 6'd17, 4'd1)); else pass_cnt++;
        for (int i = 0; i < 20; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        check_cnt++; if (viewIdx !== 4'd15) $display("FAIL ovf_view: got %0d exp 15", viewIdx); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd2, 5'd10, 5'd20, 6'd2, 4'd2))
            $display("FAIL ovf_oldest_data: got %h exp %h", dataFromRAM, rec(8'd2, 5'd10, 5'd20, 6'd2, 4'd2)); else pass_cnt++;
    endtask

    task automatic test_clear_and_miss();
        missPillId = 4'd9; timeDay = 5'd1; timeHour = 5'd1; timeMinute = 6'd1;
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        check_cnt++; if (entryCount !== 5'd0) $display("FAIL clr_count: got %0d exp 0", entryCount); else pass_cnt++;
        check_cnt++; if (logEmpty !== 1'b1) $display("FAIL clr_empty: got %b exp 1", logEmpty); else pass_cnt++;
        check_cnt++; if (overflow !== 1'b0) $display("FAIL clr_overflow: got %b exp 0", overflow); else pass_cnt++;
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL clr_view: got %0d exp 0", viewIdx); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== 28'h0) $display("FAIL clr_data: got %h exp %h", dataFromRAM, 28'h0); else pass_cnt++;
        write_rec(4'd7, 5'd31, 5'd23, 6'd59);
        tick(2);
        check_cnt++; if (dataFromRAM !== rec(8'd0, 5'd31, 5'd23, 6'd59, 4'd7))
            $display("FAIL clr_seq_restart: got %h exp %h", dataFromRAM, rec(8'd0, 5'd31, 5'd23, 6'd59, 4'd7)); else pass_cnt++;
        check_cnt++; if (entryCount !== 5'd1) $display("FAIL clr_after_count: got %0d exp 1", entryCount); else pass_cnt++;
    endtask

    task automatic test_held_level();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        missPillId = 4'd5; timeDay = 5'd2; timeHour = 5'd3; timeMinute = 6'd4;
        missEvent = 1'b1;
        tick(100);
        missEvent = 1'b0;
        tick(2);
        check_cnt++; if (entryCount !== 5'd1) $display("FAIL held_count: got %0d exp 1", entryCount); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd0, 5'd2, 5'd3, 6'd4, 4'd5))
            $display("FAIL held_data: got %h exp %h", dataFromRAM, rec(8'd0, 5'd2, 5'd3, 6'd4, 4'd5)); else pass_cnt++;
    endtask

    task automatic test_empty_scroll();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL empty_older_view: got %0d exp 0", viewIdx); else pass_cnt++;
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_cnt++; if (viewIdx !== 4'd0) $display("FAIL empty_newer_view: got %0d exp 0", viewIdx); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== 28'h0) $display("FAIL empty_data: got %h exp %h", dataFromRAM, 28'h0); else pass_cnt++;
    endtask

    task automatic test_dup();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        write_rec(4'd6, 5'd11, 5'd12, 6'd13);
        write_rec(4'd6, 5'd11, 5'd12, 6'd13);
        tick(2);
`ifdef MISSED_LOG_DUP_FILTER_EN
        check_cnt++; if (entryCount !== 5'd1) $display("FAIL dup_count: got %0d exp 1", entryCount); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd0, 5'd11, 5'd12, 6'd13, 4'd6))
            $display("FAIL dup_data: got %h exp %h", dataFromRAM, rec(8'd0, 5'd11, 5'd12, 6'd13, 4'd6)); else pass_cnt++;
        write_rec(4'd6, 5'd11, 5'd12, 6'd14);
        tick(2);
        check_cnt++; if (dataFromRAM !== rec(8'd1, 5'd11, 5'd12, 6'd14, 4'd6))
            $display("FAIL dup_next_data: got %h exp %h", dataFromRAM, rec(8'd1, 5'd11, 5'd12, 6'd14, 4'd6)); else pass_cnt++;
`else
        check_cnt++; if (entryCount !== 5'd2) $display("FAIL dup_count: got %0d exp 2", entryCount); else pass_cnt++;
        check_cnt++; if (dataFromRAM !== rec(8'd1, 5'd11, 5'd12, 6'd13, 4'd6))
            $display("FAIL dup_data: got %h exp %h", dataFromRAM, rec(8'd1, 5'd11, 5'd12, 6'd13, 4'd6)); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_three_writes();
        test_scroll();
        test_overflow();
        test_clear_and_miss();
        test_held_level();
        test_empty_scroll();
        test_dup();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
